branch_history_table: RTL and testbench

- Eight-entry, fully associative branch target buffer with 2-bit saturating counters, shared by the IF and EX stages of the pipelined CPU.
- The EX stage writes resolved branch outcomes into it. The IF stage reads it every cycle to get a predicted next PC.
- Flattened valid and state vectors go to the display mux, so table contents can be viewed on the 7-segment display.

---
 rtl/branch_history_table_if.sv | 23 ++
 rtl/branch_history_table.sv | 180 ++++++++++++++++++
 tb/tb_branch_history_table.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/branch_history_table_if.sv
// Lookup and update bus between the pipeline and the branch target buffer.
//   master: pipeline side; drives lk_pc and the upd_* resolution fields.
//   slave:  table side; returns lk_hit, lk_taken and lk_target.
interface branch_history_table_if;
  logic [31:0] lk_pc;
  logic        lk_hit;
  logic        lk_taken;
  logic [31:0] lk_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic        upd_taken;

  modport master (
    output lk_pc, upd_valid, upd_pc, upd_target, upd_taken,
    input  lk_hit, lk_taken, lk_target
  );

  modport slave (
    input  lk_pc, upd_valid, upd_pc, upd_target, upd_taken,
    output lk_hit, lk_taken, lk_target
  );
endinterface

// File: rtl/branch_history_table.sv
// Eight-entry fully associative branch target buffer with 2-bit saturating counters.
// IF reads it combinationally every cycle; EX writes resolved branch outcomes.
// Ports:
//   clk, RST   - clock, asynchronous active-high reset
//   flush      - synchronous clear of all entries (wins over an update)
//   bus        - branch_history_table_if.slave: lookup (lk_*) and update (upd_*)
//   valid_vec  - one nibble per entry, {3'h0, valid}
//   state_vec  - one nibble per entry, {2'h0, counter}
//   victim_ptr - next round-robin replacement index
// Optional: define BHT_STATS_EN to add stat_lookups, stat_hits, stat_mispredicts.
module branch_history_table #(
  parameter int unsigned ENTRIES    = 8,
  parameter logic [1:0]  INIT_STATE = 2'b10
) (
  input  logic        clk,
  input  logic        RST,
  input  logic        flush,
  branch_history_table_if.slave bus,
  output logic [31:0] valid_vec,
  output logic [31:0] state_vec,
  output logic [2:0]  victim_ptr
`ifdef BHT_STATS_EN
  ,
  output logic [15:0] stat_lookups,
  output logic [15:0] stat_hits,
  output logic [15:0] stat_mispredicts
`endif
);

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [31:0]        tag_q    [ENTRIES];
  logic [31:0]        tag_d    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];
  logic [31:0]        target_d [ENTRIES];
  logic [1:0]         cnt_q    [ENTRIES];
  logic [1:0]         cnt_d    [ENTRIES];
  logic [2:0]         victim_q, victim_d;

  logic       lk_hit;
  logic [2:0] lk_idx;
  logic       upd_hit;
  logic [2:0] upd_idx;
  logic       all_valid;
  logic [2:0] free_idx;

  // Descending scans so the lowest matching / free index wins.
  always_comb begin
    lk_hit   = 1'b0;
    lk_idx   = '0;
    upd_hit  = 1'b0;
    upd_idx  = '0;
    free_idx = '0;
    for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
      if (valid_q[i] && (tag_q[i] == bus.lk_pc)) begin
        lk_hit = 1'b1;
        lk_idx = 3'(i);
      end
      if (valid_q[i] && (tag_q[i] == bus.upd_pc)) begin
        upd_hit = 1'b1;
        upd_idx = 3'(i);
      end
      if (!valid_q[i]) begin
        free_idx = 3'(i);
      end
    end
    all_valid = &valid_q;
  end

  always_comb begin
    bus.lk_hit    = lk_hit;
    bus.lk_taken  = lk_hit & cnt_q[lk_idx][1];
    bus.lk_target = bus.lk_taken ? target_q[lk_idx] : bus.lk_pc + 32'd4;
  end

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    victim_d = victim_q;
    if (flush) begin
      valid_d  = '0;
      tag_d    = '{default: '0};
      target_d = '{default: '0};
      cnt_d    = '{default: '0};
      victim_d = '0;
    end else if (bus.upd_valid) begin
      if (upd_hit) begin
        if (bus.upd_taken) begin
          cnt_d[upd_idx]    = (cnt_q[upd_idx] == 2'b11) ? 2'b11 : cnt_q[upd_idx] + 2'b01;
          target_d[upd_idx] = bus.upd_target;
        end else begin
          // Entry stays valid even when the counter bottoms out.
          cnt_d[upd_idx] = (cnt_q[upd_idx] == 2'b00) ? 2'b00 : cnt_q[upd_idx] - 2'b01;
        end
      end else if (bus.upd_taken) begin
        if (!all_valid) begin
          valid_d[free_idx]  = 1'b1;
          tag_d[free_idx]    = bus.upd_pc;
          target_d[free_idx] = bus.upd_target;
          cnt_d[free_idx]    = INIT_STATE;
        end else begin
          tag_d[victim_q]    = bus.upd_pc;
          target_d[victim_q] = bus.upd_target;
          cnt_d[victim_q]    = INIT_STATE;
          victim_d           = victim_q + 3'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      valid_q  <= '0;
      tag_q    <= '{default: '0};
      target_q <= '{default: '0};
      cnt_q    <= '{default: '0};
      victim_q <= '0;
    end else begin
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
      victim_q <= victim_d;
    end
  end

  always_comb begin
    valid_vec = '0;
    state_vec = '0;
    for (int i = 0; i < int'(ENTRIES); i++) begin
      valid_vec[4*i +: 4] = {3'h0, valid_q[i]};
      state_vec[4*i +: 4] = {2'h0, cnt_q[i]};
    end
    victim_ptr = victim_q;
  end

`ifdef BHT_STATS_EN
  logic [15:0] lookups_q, lookups_d;
  logic [15:0] hits_q, hits_d;
  logic [15:0] mispred_q, mispred_d;
  logic        pred_taken;

  always_comb begin
    // A miss predicts not-taken.
    pred_taken = upd_hit & cnt_q[upd_idx][1];
    lookups_d  = lookups_q;
    hits_d     = hits_q;
    mispred_d  = mispred_q;
    if (flush) begin
      lookups_d = '0;
      hits_d    = '0;
      mispred_d = '0;
    end else if (bus.upd_valid) begin
      if (lookups_q != 16'hFFFF) lookups_d = lookups_q + 16'd1;
      if (upd_hit && (hits_q != 16'hFFFF)) hits_d = hits_q + 16'd1;
      if ((pred_taken != bus.upd_taken) && (mispred_q != 16'hFFFF)) begin
        mispred_d = mispred_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      lookups_q <= '0;
      hits_q    <= '0;
      mispred_q <= '0;
    end else begin
      lookups_q <= lookups_d;
      hits_q    <= hits_d;
      mispred_q <= mispred_d;
    end
  end

  assign stat_lookups     = lookups_q;
  assign stat_hits        = hits_q;
  assign stat_mispredicts = mispred_q;
`endif

endmodule

// File: tb/tb_branch_history_table.sv
module tb_branch_history_table;
  logic        clk = 1'b0;
  logic        RST;
  logic        flush;
  logic [31:0] valid_vec;
  logic [31:0] state_vec;
  logic [2:0]  victim_ptr;
`ifdef BHT_STATS_EN
  logic [15:0] stat_lookups, stat_hits, stat_mispredicts;
`endif

  int errors = 0;
  int checks = 0;

  branch_history_table_if bif ();

  branch_history_table dut (
    .clk        (clk),
    .RST        (RST),
    .flush      (flush),
    .bus        (bif),
    .valid_vec  (valid_vec),
    .state_vec  (state_vec),
    .victim_ptr (victim_ptr)
`ifdef BHT_STATS_EN
    ,
    .stat_lookups     (stat_lookups),
    .stat_hits        (stat_hits),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic [31:0] pc, input logic [31:0] tgt, input logic tk);
    bif.upd_valid  = 1'b1;
    bif.upd_pc     = pc;
    bif.upd_target = tgt;
    bif.upd_taken  = tk;
    tick();
    bif.upd_valid  = 1'b0;
  endtask

  task automatic look(input logic [31:0] pc);
    bif.lk_pc = pc;
    #1;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  initial begin
    RST            = 1'b1;
    flush          = 1'b0;
    bif.lk_pc      = 32'h10;
    bif.upd_valid  = 1'b0;
    bif.upd_pc     = '0;
    bif.upd_target = '0;
    bif.upd_taken  = 1'b0;
    #12;
    chk("rst_hit", {31'd0, bif.lk_hit}, 32'd0);
    chk("rst_target", bif.lk_target, 32'h14);
    RST = 1'b0;
    tick();
    look(32'h10);
    chk("reset_hit", {31'd0, bif.lk_hit}, 32'd0);
    chk("reset_taken", {31'd0, bif.lk_taken}, 32'd0);
    chk("reset_target", bif.lk_target, 32'h14);
    chk("reset_valid_vec", valid_vec, 32'h0);
    chk("reset_state_vec", state_vec, 32'h0);
    chk("reset_victim", {29'd0, victim_ptr}, 32'd0);

    // First allocation lands in entry 0 at weakly taken.
    upd(32'h20, 32'h40, 1'b1);
    look(32'h20);
    chk("alloc_hit", {31'd0, bif.lk_hit}, 32'd1);
    chk("alloc_taken", {31'd0, bif.lk_taken}, 32'd1);
    chk("alloc_target", bif.lk_target, 32'h40);
    chk("alloc_valid_vec", valid_vec, 32'h1);
    chk("alloc_state_vec", state_vec, 32'h2);

    upd(32'h20, 32'h40, 1'b1);
    chk("inc_to_3", state_vec, 32'h3);
    upd(32'h20, 32'h40, 1'b1);
    upd(32'h20, 32'h40, 1'b1);
    chk("sat_at_3", state_vec, 32'h3);
    upd(32'h20, 32'h40, 1'b0);
    chk("dec_to_2", state_vec, 32'h2);
    chk("dec2_taken", {31'd0, bif.lk_taken}, 32'd1);
    upd(32'h20, 32'h40, 1'b0);
    chk("dec_to_1", state_vec, 32'h1);
    chk("dec1_taken", {31'd0, bif.lk_taken}, 32'd0);
    chk("dec1_target", bif.lk_target, 32'h24);
    upd(32'h20, 32'h40, 1'b0);
    chk("dec_to_0", state_vec, 32'h0);
    chk("dec0_hit", {31'd0, bif.lk_hit}, 32'd1);
    chk("dec0_valid", valid_vec, 32'h1);

    // Not-taken miss must not allocate.
    upd(32'h30, 32'h99, 1'b0);
    chk("nt_miss_valid", valid_vec, 32'h1);
    look(32'h30);
    chk("nt_miss_hit", {31'd0, bif.lk_hit}, 32'd0);

    do_flush();
    chk("flush_valid", valid_vec, 32'h0);
    for (int i = 0; i < 8; i++) upd(32'h100 + 32'(4 * i), 32'h1000 + 32'(i), 1'b1);
    chk("fill_valid", valid_vec, 32'h1111_1111);
    chk("fill_state", state_vec, 32'h2222_2222);
    chk("fill_victim", {29'd0, victim_ptr}, 32'd0);

    upd(32'h200, 32'h2000, 1'b1);
    chk("repl_victim", {29'd0, victim_ptr}, 32'd1);
    look(32'h100);
    chk("repl_old_miss", {31'd0, bif.lk_hit}, 32'd0);
    look(32'h200);
    chk("repl_new_target", bif.lk_target, 32'h2000);
    tick();

    // Victims go 1..7, wrap to 0, then 1; pointer ends at 2.
    for (int k = 0; k < 9; k++) begin
      upd(32'h204 + 32'(4 * k), 32'h3000 + 32'(k), 1'b1);
      if (k == 6) chk("victim_wrap", {29'd0, victim_ptr}, 32'd0);
    end
    chk("victim_end", {29'd0, victim_ptr}, 32'd2);
    look(32'h104);
    chk("repl_104_miss", {31'd0, bif.lk_hit}, 32'd0);
    look(32'h200);
    chk("repl_200_miss", {31'd0, bif.lk_hit}, 32'd0);
    look(32'h220);
    chk("repl_220_target", bif.lk_target, 32'h3007);
    chk("repl_state", state_vec, 32'h2222_2222);

    // Read-before-write on the same PC.
    do_flush();
    upd(32'h20, 32'h40, 1'b1);
    upd(32'h20, 32'h40, 1'b0);
    bif.lk_pc      = 32'h20;
    bif.upd_valid  = 1'b1;
    bif.upd_pc     = 32'h20;
    bif.upd_target = 32'h44;
    bif.upd_taken  = 1'b1;
    #1;
    chk("rbw_before_taken", {31'd0, bif.lk_taken}, 32'd0);
    chk("rbw_before_target", bif.lk_target, 32'h24);
    tick();
    bif.upd_valid = 1'b0;
    #1;
    chk("rbw_after_taken", {31'd0, bif.lk_taken}, 32'd1);
    chk("rbw_after_target", bif.lk_target, 32'h44);

    // flush beats a simultaneous update.
    flush          = 1'b1;
    bif.upd_valid  = 1'b1;
    bif.upd_pc     = 32'h50;
    bif.upd_target = 32'h500;
    bif.upd_taken  = 1'b1;
    tick();
    flush         = 1'b0;
    bif.upd_valid = 1'b0;
    look(32'h50);
    chk("flush_upd_valid", valid_vec, 32'h0);
    chk("flush_upd_hit", {31'd0, bif.lk_hit}, 32'd0);

    // Asynchronous reset between edges.
    upd(32'h60, 32'h600, 1'b1);
    look(32'h60);
    chk("pre_rst_hit", {31'd0, bif.lk_hit}, 32'd1);
    #1;
    RST = 1'b1;
    #1;
    chk("async_rst_valid", valid_vec, 32'h0);
    chk("async_rst_hit", {31'd0, bif.lk_hit}, 32'd0);
    chk("async_rst_target", bif.lk_target, 32'h64);
    RST = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
